// File: rtl/banner_scroll_ctrl.sv
// rtl/banner_scroll_ctrl.sv - step/pause sequencer driving the scrolling banner's enable and dir
// Sweeps STEPS positions left, pauses, sweeps right, pauses, repeats until stop.
module banner_scroll_ctrl #(
    parameter int CNT_W       = 16,
    parameter int TICK_DIV    = 4,
    parameter int STEPS       = 10,
    parameter int PAUSE_TICKS = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic stop,
    output logic enable,
    output logic dir,
    output logic busy,
    output logic sweep_done
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LEFT    = 3'd1;
    localparam logic [2:0] S_PAUSE_L = 3'd2;
    localparam logic [2:0] S_RIGHT   = 3'd3;
    localparam logic [2:0] S_PAUSE_R = 3'd4;

    localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] STEP_LAST  = CNT_W'(STEPS - 1);
    localparam logic [CNT_W-1:0] PAUSE_LAST = CNT_W'((PAUSE_TICKS > 0) ? PAUSE_TICKS - 1 : 0);

    if (TICK_DIV < 1 || longint'(TICK_DIV) >= (longint'(1) << CNT_W)) begin : g_bad_tick_div
        $error("TICK_DIV out of range");
    end
    if (STEPS < 1 || longint'(STEPS) >= (longint'(1) << CNT_W)) begin : g_bad_steps
        $error("STEPS out of range");
    end
    if (PAUSE_TICKS < 0 || longint'(PAUSE_TICKS) >= (longint'(1) << CNT_W)) begin : g_bad_pause
        $error("PAUSE_TICKS out of range");
    end

    logic [2:0]       state;
    logic [CNT_W-1:0] prescaler;
    logic [CNT_W-1:0] step_cnt;
    logic [CNT_W-1:0] pause_cnt;
    logic             turn;
    logic             tick;

    assign tick = (prescaler == TICK_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            prescaler  <= '0;
            step_cnt   <= '0;
            pause_cnt  <= '0;
            turn       <= 1'b0;
            enable     <= 1'b0;
            dir        <= 1'b1;
            busy       <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            enable     <= 1'b0;
            sweep_done <= 1'b0;
            if (state == S_IDLE) begin
                prescaler <= '0;
                step_cnt  <= '0;
                pause_cnt <= '0;
                turn      <= 1'b0;
                if (start && !stop) begin
                    state <= S_LEFT;
                    dir   <= 1'b1;
                    busy  <= 1'b1;
                end
            end else if (stop) begin
                state     <= S_IDLE;
                busy      <= 1'b0;
                prescaler <= '0;
                step_cnt  <= '0;
                pause_cnt <= '0;
                turn      <= 1'b0;
            end else if (turn) begin
                // Direct turnaround: flip dir one cycle after the last enable, then start a full period.
                turn      <= 1'b0;
                dir       <= (state == S_LEFT);
                prescaler <= '0;
            end else begin
                prescaler <= tick ? '0 : prescaler + 1'b1;
                case (state)
                    S_LEFT, S_RIGHT: begin
                        if (tick) begin
                            enable <= 1'b1;
                            if (step_cnt == STEP_LAST) begin
                                sweep_done <= 1'b1;
                                step_cnt   <= '0;
                                if (PAUSE_TICKS == 0) begin
                                    state <= (state == S_LEFT) ? S_RIGHT : S_LEFT;
                                    turn  <= 1'b1;
                                end else begin
                                    state <= (state == S_LEFT) ? S_PAUSE_L : S_PAUSE_R;
                                end
                            end else begin
                                step_cnt <= step_cnt + 1'b1;
                            end
                        end
                    end
                    S_PAUSE_L, S_PAUSE_R: begin
                        if (tick) begin
                            if (pause_cnt == PAUSE_LAST) begin
                                pause_cnt <= '0;
                                state     <= (state == S_PAUSE_L) ? S_RIGHT : S_LEFT;
                                dir       <= (state == S_PAUSE_R);
                            end else begin
                                pause_cnt <= pause_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_banner_scroll_ctrl.sv
// tb/tb_banner_scroll_ctrl.sv - self-checking bench for banner_scroll_ctrl
module tb_banner_scroll_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, stop, enable, dir, busy, sweep_done;
    logic reset1, start1, stop1, enable1, dir1, busy1, sweep_done1;

    banner_scroll_ctrl #(.CNT_W(16), .TICK_DIV(4), .STEPS(3), .PAUSE_TICKS(2)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .enable(enable), .dir(dir), .busy(busy), .sweep_done(sweep_done)
    );

    banner_scroll_ctrl #(.CNT_W(16), .TICK_DIV(1), .STEPS(3), .PAUSE_TICKS(0)) dut1 (
        .clk(clk), .reset(reset1), .start(start1), .stop(stop1),
        .enable(enable1), .dir(dir1), .busy(busy1), .sweep_done(sweep_done1)
    );

    typedef struct {
        int   cyc;
        logic dir;
        logic done;
    } ev_t;

    ev_t  q0[$];
    ev_t  q1[$];
    ev_t  e0;
    ev_t  e1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic prev_dir0 = 1'b1;
    logic prev_dir1 = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitors: every enable pulse must match the next expected event.
    always @(negedge clk) begin
        if (enable === 1'b1) begin
            n_checks++;
            if (q0.size() == 0) begin
                n_fail++;
                $display("FAIL dut_unexpected_enable cyc=%0d dir=%b required no enable", cyc, dir);
            end else begin
                e0 = q0.pop_front();
                if (cyc !== e0.cyc || dir !== e0.dir || sweep_done !== e0.done) begin
                    n_fail++;
                    $display("FAIL dut_enable_event got cyc=%0d dir=%b done=%b required cyc=%0d dir=%b done=%b",
                             cyc, dir, sweep_done, e0.cyc, e0.dir, e0.done);
                end
            end
            n_checks++;
            if (dir !== prev_dir0) begin
                n_fail++;
                $display("FAIL dut_dir_changed_with_enable cyc=%0d dir=%b required %b", cyc, dir, prev_dir0);
            end
        end else if (sweep_done === 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL dut_sweep_done_without_enable cyc=%0d got 1 required 0", cyc);
        end
        prev_dir0 = dir;
    end

    always @(negedge clk) begin
        if (enable1 === 1'b1) begin
            n_checks++;
            if (q1.size() == 0) begin
                n_fail++;
                $display("FAIL dut1_unexpected_enable cyc=%0d dir=%b required no enable", cyc, dir1);
            end else begin
                e1 = q1.pop_front();
                if (cyc !== e1.cyc || dir1 !== e1.dir || sweep_done1 !== e1.done) begin
                    n_fail++;
                    $display("FAIL dut1_enable_event got cyc=%0d dir=%b done=%b required cyc=%0d dir=%b done=%b",
                             cyc, dir1, sweep_done1, e1.cyc, e1.dir, e1.done);
                end
            end
            n_checks++;
            if (dir1 !== prev_dir1) begin
                n_fail++;
                $display("FAIL dut1_dir_changed_with_enable cyc=%0d dir=%b required %b", cyc, dir1, prev_dir1);
            end
        end else if (sweep_done1 === 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL dut1_sweep_done_without_enable cyc=%0d got 1 required 0", cyc);
        end
        prev_dir1 = dir1;
    end

    task automatic wait_to(input int target);
        if (target > cyc) begin
            repeat (target - cyc) @(posedge clk);
            #1;
        end
    endtask

    task automatic push0(input int c, input logic d, input logic done);
        ev_t e;
        e.cyc = c; e.dir = d; e.done = done;
        q0.push_back(e);
    endtask

    task automatic push1(input int c, input logic d, input logic done);
        ev_t e;
        e.cyc = c; e.dir = d; e.done = done;
        q1.push_back(e);
    endtask

    // Pulse start on dut for one edge; returns the edge number E0 that sampled it.
    task automatic pulse_start(output int e);
        start = 1'b1;
        @(posedge clk);
        #1;
        e = cyc;
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
    endtask

    task automatic push_left_sweep(input int e);
        push0(e + 4, 1'b1, 1'b0);
        push0(e + 8, 1'b1, 1'b0);
        push0(e + 12, 1'b1, 1'b1);
    endtask

    task automatic check_q0_empty(input string name);
        n_checks++;
        if (q0.size() != 0) begin
            n_fail++;
            $display("FAIL %s pending_enables=%0d required 0 (next cyc=%0d)", name, q0.size(), q0[0].cyc);
        end
    endtask

    task automatic check_idle(input string name, input logic exp_dir);
        n_checks++;
        if (enable !== 1'b0 || busy !== 1'b0 || sweep_done !== 1'b0 || dir !== exp_dir) begin
            n_fail++;
            $display("FAIL %s got en=%b busy=%b done=%b dir=%b required en=0 busy=0 done=0 dir=%b",
                     name, enable, busy, sweep_done, dir, exp_dir);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; stop = 1'b0;
        reset1 = 1'b1; start1 = 1'b0; stop1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset_state", 1'b1);
        n_checks++;
        if (enable1 !== 1'b0 || busy1 !== 1'b0 || sweep_done1 !== 1'b0 || dir1 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state_dut1 got en=%b busy=%b done=%b dir=%b required 0 0 0 1",
                     enable1, busy1, sweep_done1, dir1);
        end
        reset = 1'b0;
        reset1 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check_idle("idle_hold", 1'b1);
        end
    endtask

    task automatic test_sweep();
        int e;
        pulse_start(e);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL sweep_busy got %b required 1", busy);
        end
        push_left_sweep(e);
        push0(e + 24, 1'b0, 1'b0);
        push0(e + 28, 1'b0, 1'b0);
        push0(e + 32, 1'b0, 1'b1);
        wait_to(e + 19);
        n_checks++;
        if (dir !== 1'b1) begin
            n_fail++;
            $display("FAIL sweep_dir_before_turn got %b required 1", dir);
        end
        wait_to(e + 20);
        n_checks++;
        if (dir !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep_dir_after_turn got %b required 0", dir);
        end
        wait_to(e + 34);
        check_q0_empty("sweep_all_enables");
        pulse_stop();
        check_idle("sweep_stop_holds_dir", 1'b0);
        wait_to(cyc + 3);
    endtask

    task automatic test_stop();
        int e;
        // Restart after a stop that left dir=0 must begin with a left sweep.
        pulse_start(e);
        n_checks++;
        if (dir !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_dir got %b required 1", dir);
        end
        push0(e + 4, 1'b1, 1'b0);
        push0(e + 8, 1'b1, 1'b0);
        wait_to(e + 10);
        pulse_stop();
        check_idle("stop_mid_left", 1'b1);
        wait_to(e + 20);
        check_q0_empty("stop_no_more_enables");
        // Stop sampled on the very tick edge suppresses that enable.
        pulse_start(e);
        wait_to(e + 3);
        pulse_stop();
        check_idle("stop_beats_tick", 1'b1);
        wait_to(e + 12);
        check_q0_empty("stop_beats_tick_queue");
    endtask

    task automatic test_start_stop();
        int e;
        start = 1'b1;
        stop = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop = 1'b0;
        check_idle("start_and_stop_in_idle", 1'b1);
        wait_to(cyc + 5);
        pulse_start(e);
        push_left_sweep(e);
        // start while busy is ignored
        wait_to(e + 5);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_to(e + 14);
        check_q0_empty("start_while_busy");
        pulse_stop();
        check_idle("start_stop_end", 1'b1);
    endtask

    task automatic test_reset_mid();
        int e;
        pulse_start(e);
        push_left_sweep(e);
        push0(e + 24, 1'b0, 1'b0);
        wait_to(e + 26);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_idle("reset_mid_right", 1'b1);
        check_q0_empty("reset_mid_right_queue");
        wait_to(cyc + 2);
        pulse_start(e);
        push_left_sweep(e);
        wait_to(e + 14);
        check_q0_empty("reset_then_left_sweep");
        pulse_stop();
    endtask

    task automatic test_fast();
        int e;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        e = cyc;
        start1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            for (int k = 1; k <= 3; k++) begin
                push1(e + 4 * i + k, (i % 2 == 0) ? 1'b1 : 1'b0, (k == 3) ? 1'b1 : 1'b0);
            end
        end
        wait_to(e + 3);
        n_checks++;
        if (dir1 !== 1'b1) begin
            n_fail++;
            $display("FAIL fast_dir_last_left got %b required 1", dir1);
        end
        wait_to(e + 4);
        n_checks++;
        if (dir1 !== 1'b0 || enable1 !== 1'b0) begin
            n_fail++;
            $display("FAIL fast_turn got dir=%b en=%b required dir=0 en=0", dir1, enable1);
        end
        wait_to(e + 11);
        stop1 = 1'b1;
        @(posedge clk);
        #1;
        stop1 = 1'b0;
        n_checks++;
        if (busy1 !== 1'b0 || enable1 !== 1'b0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL fast_end got busy=%b en=%b pending=%0d required 0 0 0", busy1, enable1, q1.size());
        end
        wait_to(cyc + 4);
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_stop();
        test_start_stop();
        test_reset_mid();
        test_fast();
        wait_to(cyc + 10);
        check_q0_empty("final_queue");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
